y_merge: RTL and testbench

Y_MERGE -- requirements
Module: y_merge

---
 rtl/y_pkg.sv | 32 +++
 rtl/y_fifo.sv | 72 +++++++
 rtl/y_merge.sv | 179 +++++++++++++++++
 tb/tb_y_merge.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y_pkg.sv
// Shared widths, the Y saturation limit, and the pixel word that is buffered
// between the luma adder and the output port.
package y_pkg;

    localparam int YR_W  = 7;
    localparam int YG_W  = 8;
    localparam int YB_W  = 5;
    localparam int Y_W   = 8;
    localparam int SUM_W = 9;

    localparam logic [Y_W-1:0] Y_SAT = 8'd255;

    typedef struct packed {
        logic [Y_W-1:0] y;
        logic           sof;
        logic           eol;
        logic           eof;
    } y_pix_t;

    localparam int PIX_W = $bits(y_pix_t);

    function automatic logic [Y_W-1:0] sat_y(input logic [SUM_W-1:0] sum);
        logic [Y_W-1:0] res;
        if (sum > {1'b0, Y_SAT}) begin
            res = Y_SAT;
        end else begin
            res = sum[Y_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/y_fifo.sv
// First-word-fall-through buffer; head entry is visible on oData whenever
// oEmpty is low. A push while full is only taken when a pop frees the slot.
module y_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iData,
    input  logic             iPop,
    output logic [WIDTH-1:0] oData,
    output logic             oFull,
    output logic             oEmpty,
    output logic [CNT_W-1:0] oCount
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Occupancy flags and accepted push/pop strobes
    always_comb begin
        full_s    = (count_r == FULL_CNT);
        empty_s   = (count_r == {CNT_W{1'b0}});
        pop_ok_s  = iPop & ~empty_s;
        push_ok_s = iPush & (~full_s | pop_ok_s);
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge iClk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= iData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign oData  = mem_r[rd_ptr_r];
    assign oFull  = full_s;
    assign oEmpty = empty_s;
    assign oCount = count_r;

endmodule

// File: rtl/y_merge.sv
// Adds the three luma partials into a saturated grey pixel, tracks the frame
// position to tag line/frame boundaries, and buffers results for a stalling sink.
module y_merge
    import y_pkg::*;
#(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            iClk,
    input  logic            iReset,
    input  logic            iValid,
    input  logic            iSof,
    input  logic            iEol,
    input  logic [YR_W-1:0] iYR,
    input  logic [YG_W-1:0] iYG,
    input  logic [YB_W-1:0] iYB,
    input  logic            iReady,
    output logic [Y_W-1:0]  oY,
    output logic            oValid,
    output logic            oSof,
    output logic            oEol,
    output logic            oEof,
    output logic            oOverflow,
    output logic            oLineErr
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic             v1_r;
    logic             sof1_r;
    logic             eol1_r;
    logic             v2_r;
    y_pix_t           pix2_r;
    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic             frame_wrap_r;
    logic             line_err_r;
    logic             ovf_r;

    logic [SUM_W-1:0] sum_s;
    logic [COL_W-1:0] cur_col_s;
    logic [ROW_W-1:0] cur_row_s;
    logic [COL_W-1:0] next_col_s;
    logic [ROW_W-1:0] next_row_s;
    logic             col_last_s;
    logic             row_last_s;
    logic             line_end_s;
    logic             err_s;
    y_pix_t           pix_s;

    logic [PIX_W-1:0] fifo_q_s;
    y_pix_t           fifo_pix_s;
    logic             full_s;
    logic             empty_s;
    logic [CNT_W-1:0] count_s;
    logic             pop_s;
    logic             drop_s;

    // Stage 1: delay the strobes so they line up with the partials
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            v1_r   <= 1'b0;
            sof1_r <= 1'b0;
            eol1_r <= 1'b0;
        end else begin
            v1_r   <= iValid;
            sof1_r <= iValid & iSof;
            eol1_r <= iValid & iEol;
        end
    end

    // Position of the aligned pixel, next position, and geometry errors
    always_comb begin
        sum_s = SUM_W'(iYR) + SUM_W'(iYG) + SUM_W'(iYB);
        if (sof1_r) begin
            cur_col_s = {COL_W{1'b0}};
            cur_row_s = {ROW_W{1'b0}};
        end else begin
            cur_col_s = col_r;
            cur_row_s = row_r;
        end
        col_last_s = (cur_col_s == COL_LAST);
        row_last_s = (cur_row_s == ROW_LAST);
        line_end_s = eol1_r | col_last_s;
        if (line_end_s) begin
            next_col_s = {COL_W{1'b0}};
            if (row_last_s) begin
                next_row_s = {ROW_W{1'b0}};
            end else begin
                next_row_s = cur_row_s + 1'b1;
            end
        end else begin
            next_col_s = cur_col_s + 1'b1;
            next_row_s = cur_row_s;
        end
        // a short line, a missing eol, or a row beyond the frame without sof
        err_s     = v1_r & ((eol1_r ^ col_last_s) | (frame_wrap_r & ~sof1_r));
        pix_s.y   = sat_y(sum_s);
        pix_s.sof = sof1_r;
        pix_s.eol = eol1_r;
        pix_s.eof = col_last_s & row_last_s;
    end

    // Stage 2: registered pixel word plus frame position tracking
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            v2_r         <= 1'b0;
            pix2_r       <= '{y: 8'd0, sof: 1'b0, eol: 1'b0, eof: 1'b0};
            col_r        <= {COL_W{1'b0}};
            row_r        <= {ROW_W{1'b0}};
            frame_wrap_r <= 1'b0;
            line_err_r   <= 1'b0;
        end else begin
            v2_r       <= v1_r;
            line_err_r <= line_err_r | err_s;
            if (v1_r) begin
                pix2_r       <= pix_s;
                col_r        <= next_col_s;
                row_r        <= next_row_s;
                frame_wrap_r <= line_end_s & row_last_s;
            end
        end
    end

    assign pop_s  = iReady & (count_s != {CNT_W{1'b0}});
    assign drop_s = v2_r & full_s & ~pop_s;

    // Sticky overflow when a finished pixel finds no room
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | drop_s;
        end
    end

    y_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iClk   (iClk),
        .iReset (iReset),
        .iPush  (v2_r),
        .iData  (pix2_r),
        .iPop   (pop_s),
        .oData  (fifo_q_s),
        .oFull  (full_s),
        .oEmpty (empty_s),
        .oCount (count_s)
    );

    assign fifo_pix_s = fifo_q_s;

    // Output word is forced to zero whenever the buffer holds nothing
    always_comb begin
        oValid = ~empty_s;
        if (~empty_s) begin
            oY   = fifo_pix_s.y;
            oSof = fifo_pix_s.sof;
            oEol = fifo_pix_s.eol;
            oEof = fifo_pix_s.eof;
        end else begin
            oY   = 8'd0;
            oSof = 1'b0;
            oEol = 1'b0;
            oEof = 1'b0;
        end
    end

    assign oOverflow = ovf_r;
    assign oLineErr  = line_err_r;

endmodule

// File: tb/tb_y_merge.sv
// Scoreboard bench for y_merge on a 4x2 frame with a 4-entry buffer.
module tb_y_merge;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;

    logic       iClk   = 1'b0;
    logic       iReset = 1'b1;
    logic       iValid = 1'b0;
    logic       iSof   = 1'b0;
    logic       iEol   = 1'b0;
    logic [6:0] iYR    = 7'd0;
    logic [7:0] iYG    = 8'd0;
    logic [4:0] iYB    = 5'd0;
    logic       iReady = 1'b1;
    logic [7:0] oY;
    logic       oValid, oSof, oEol, oEof, oOverflow, oLineErr;

    y_merge #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
        .iClk(iClk), .iReset(iReset), .iValid(iValid), .iSof(iSof), .iEol(iEol),
        .iYR(iYR), .iYG(iYG), .iYB(iYB), .iReady(iReady),
        .oY(oY), .oValid(oValid), .oSof(oSof), .oEol(oEol), .oEof(oEof),
        .oOverflow(oOverflow), .oLineErr(oLineErr)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [7:0] y;
        logic       sof;
        logic       eol;
        logic       eof;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic [6:0] p_yr = 7'd0;
    logic [7:0] p_yg = 8'd0;
    logic [4:0] p_yb = 5'd0;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: every accepted pixel is matched against the queue head
    always @(negedge iClk) begin
        exp_t e;
        if (!iReset && oValid && iReady) begin
            if (sb.size() == 0) begin
                check("unexpected_pixel", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("y", oY, e.y);
                check("tags", {oSof, oEol, oEof}, {e.sof, e.eol, e.eof});
            end
        end
    end

    // One clock of stimulus; partials of the previous cycle's pixel go out now
    task automatic step(input logic v, input logic s, input logic e,
                        input logic [6:0] yr, input logic [7:0] yg, input logic [4:0] yb,
                        input logic rdy);
        @(posedge iClk);
        #1;
        iYR    = p_yr;
        iYG    = p_yg;
        iYB    = p_yb;
        iValid = v;
        iSof   = s;
        iEol   = e;
        iReady = rdy;
        p_yr   = yr;
        p_yg   = yg;
        p_yb   = yb;
    endtask

    task automatic px(input int yr, input int yg, input int yb,
                      input logic s, input logic e, input logic eof,
                      input logic keep, input logic rdy);
        exp_t x;
        int   sum;
        sum   = yr + yg + yb;
        x.y   = (sum > 255) ? 8'd255 : sum[7:0];
        x.sof = s;
        x.eol = e;
        x.eof = eof;
        if (keep) sb.push_back(x);
        step(1'b1, s, e, yr[6:0], yg[7:0], yb[4:0], rdy);
    endtask

    task automatic px_rand(input logic s, input logic e, input logic eof,
                           input logic keep, input logic rdy);
        px(int'($urandom_range(0, 127)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 31)), s, e, eof, keep, rdy);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, 7'($urandom), 8'($urandom), 5'($urandom), rdy);
    endtask

    task automatic drain();
        int k;
        idle(1'b1);
        idle(1'b1);
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge iClk);
            k++;
        end
        check("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge iClk);
        iReset = 1'b1;
        iValid = 1'b0;
        iSof   = 1'b0;
        iEol   = 1'b0;
        iReady = 1'b1;
        sb.delete();
        #1;
        check("rst_outs", {oValid, oY, oSof, oEol, oEof, oOverflow, oLineErr}, 32'd0);
        repeat (2) @(posedge iClk);
        #1;
        iReset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int k;

        // single pixel latency and pulse width
        do_reset();
        px(76, 149, 29, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        c0 = cyc;
        idle(1'b1);
        k = 0;
        do begin
            @(negedge iClk);
            k++;
        end while (!oValid && k < 10);
        check("latency", cyc - c0, 32'd3);
        @(negedge iClk);
        check("one_cycle_valid", oValid, 1'b0);

        // saturation and no-sof start after reset
        do_reset();
        px(127, 255, 31, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        px(100, 50, 10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        px(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();
        check("no_sof_lineerr", oLineErr, 1'b0);

        // two well-formed frames, then a row past the frame without sof
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                px_rand(i == 0, (i == 3) || (i == 7), i == 7, 1'b1, 1'b1);
            end
        end
        drain();
        check("frame_lineerr", oLineErr, 1'b0);
        check("frame_ovf", oOverflow, 1'b0);
        px_rand(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();
        check("overrun_lineerr", oLineErr, 1'b1);

        // short line: eol at column 2 restarts at column 0 of the next row
        do_reset();
        px_rand(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        px_rand(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        px_rand(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            px_rand(1'b0, i == 3, i == 3, 1'b1, 1'b1);
        end
        drain();
        check("short_line_lineerr", oLineErr, 1'b1);

        // missing eol: column wraps on its own, eof still lands on pixel 7
        do_reset();
        for (int i = 0; i < 8; i++) begin
            px_rand(i == 0, 1'b0, i == 7, 1'b1, 1'b1);
        end
        drain();
        check("no_eol_lineerr", oLineErr, 1'b1);

        // stalled sink: 6 pixels, 4 kept, then a push that coincides with a pop
        do_reset();
        for (int i = 0; i < 6; i++) begin
            px_rand(1'b0, 1'b0, 1'b0, i < 4, 1'b0);
        end
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        check("ovf_set", oOverflow, 1'b1);
        check("full_valid", oValid, 1'b1);
        check("hold_y_a", oY, sb[0].y);
        idle(1'b0);
        check("hold_y_b", oY, sb[0].y);
        px_rand(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b1);
        drain();

        // reset while pixels are in flight
        do_reset();
        px_rand(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        px_rand(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        px_rand(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        check("pre_rst_valid", oValid, 1'b1);
        check("pre_rst_lineerr", oLineErr, 1'b1);
        #2;
        iReset = 1'b1;
        #1;
        check("mid_rst_outs", {oValid, oY, oSof, oEol, oEof, oOverflow, oLineErr}, 32'd0);
        @(posedge iClk);
        #1;
        iReset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
        end
        check("no_stale", oValid, 1'b0);
        px(76, 149, 29, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();
        check("post_rst_lineerr", oLineErr, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
